cnn_image_pool_bcast: RTL and testbench
=======================================

Name: cnn_image_pool_bcast

Overview:
Image-pooling branch of the ASPP head, directly upstream of the 5-input concat stage; its output drives that stage's no5 input pair (in_no5 / valid_in_no5).
- Consumes one feature map streamed channel-planar: all IMAGE_WIDTH*IMAGE_HEIGHT pixels of channel 0, then channel 1, and so on.
- Computes the per-channel spatial mean.
- Re-emits that mean IMAGE_SIZE times, giving a bilinear-equivalent upsample of a 1x1 map, in the same channel-planar order.

Parameters:
- DATA_WIDTH, 32: sample width, two's-complement fixed point (format transparent to this block).
- IMAGE_WIDTH, 32: plane width in pixels; must be a power of two.
- IMAGE_HEIGHT, 32: plane height in pixels; must be a power of two.
- CHANNEL_NUM, 256: channels per frame.
- Derived localparams:
  - IMAGE_SIZE = IMAGE_WIDTH*IMAGE_HEIGHT.
  - LOG2_SIZE = log2(IMAGE_SIZE).
  - ACC_WIDTH = DATA_WIDTH + LOG2_SIZE.

Ports:
- clk, input, 1: single clock; all logic on posedge.
- reset, input, 1: asynchronous, active-high reset.
- valid_in, input, 1: in carries a pixel this cycle.
- in, input, DATA_WIDTH: pixel sample, signed.
- out, output, DATA_WIDTH: broadcast channel mean, registered.
- valid_out, output, 1: out is valid this cycle.
- ch_idx, output, 16: channel index of the current out beat.
- frame_done, output, 1: one-cycle pulse coincident with the final out beat of channel CHANNEL_NUM-1.
- overrun, output, 1: sticky error flag, cleared only by reset.

Behaviour:
- Reset (asynchronous, immediate) clears:
  - outputs: out=0, valid_out=0, ch_idx=0, frame_done=0, overrun=0;
  - internal state: accumulator, pixel counter, input channel counter and broadcast counter all 0.
- Input side, per valid_in beat:
  - acc += sign_extend(in) to ACC_WIDTH;
  - pix_cnt advances 0..IMAGE_SIZE-1;
  - cycles with valid_in=0 change nothing.
- Last pixel of a plane (valid_in while pix_cnt==IMAGE_SIZE-1), on that edge:
  - mean = (acc + in) >>> LOG2_SIZE, arithmetic shift (floor), low DATA_WIDTH bits; no saturation needed;
  - out <= mean, valid_out <= 1, bcast_cnt <= IMAGE_SIZE-1;
  - ch_idx <= input channel counter;
  - acc <= 0, pix_cnt <= 0;
  - input channel counter advances, wrapping CHANNEL_NUM-1 -> 0.
- Latency: first out beat is the cycle after the last input pixel's edge.
- Broadcast: one beat per cycle, IMAGE_SIZE consecutive cycles, valid_out continuously high; no backpressure.
  - Each edge with bcast_cnt>0: bcast_cnt--, out held.
  - Edge with bcast_cnt==0 and no new load: valid_out <= 0.
- frame_done = 1 exactly on the beat where valid_out=1, bcast_cnt==0 and ch_idx==CHANNEL_NUM-1.
- Rate rule: input is at most 1 pixel/cycle, so a plane's last pixel never arrives before the previous broadcast's final beat.
- Back-to-back planes: a load on the edge where bcast_cnt==0 reloads seamlessly; valid_out stays high with no bubble, and ch_idx steps.
- Load while bcast_cnt>0 (rate violation):
  - the new mean wins and the broadcast restarts with a full IMAGE_SIZE count;
  - overrun <= 1.
- Frame wrap: the input channel counter wraps to 0 after CHANNEL_NUM planes; the next frame needs no idle gap.
- Reset mid-plane or mid-broadcast:
  - all partial sums are discarded and the broadcast aborts (valid_out=0 immediately);
  - the next valid_in after release is pixel 0 of channel 0.

Test Plan:
- Setup: IMAGE_WIDTH=2, IMAGE_HEIGHT=2, CHANNEL_NUM=3, continuous valid_in.
  - Stimulus: ch0 = 4,8,12,16; ch1 = -1,-2,-3,-4; ch2 = 0,0,0,1.
  - Required: out = 10 x4 with ch_idx 0, then -3 x4 (floor of -10/4) with ch_idx 1, then 0 x4 (floor of 1/4) with ch_idx 2.
  - Required: valid_out high for 12 consecutive cycles with no bubble; frame_done on the 12th beat only.
- Gappy input (valid_in toggling 1,0,1,0) with ch0 = 4,4,4,4 -> out=4 x4, starting the cycle after the 4th beat's edge; valid_out low before that.
- Extremes: all samples 0x7FFFFFFF -> out 0x7FFFFFFF; all 0x80000000 -> out 0x80000000 (no accumulator overflow).
- Rate violation: force the plane-end load while bcast_cnt>0 -> overrun=1 and sticky; broadcast restarts with the new mean for 4 beats.
- Reset: assert reset on the 2nd broadcast beat -> valid_out=0 and overrun=0 immediately; after release, a fresh frame reproduces scenario 1 exactly.
- Two frames back-to-back -> 24 contiguous beats; ch_idx sequence 0,1,2,0,1,2 (each held 4 beats); frame_done pulses on beats 12 and 24.

Source files
------------

// File: rtl/cnn_image_pool_bcast.sv
// ASPP image-pooling branch: averages each channel plane of a channel-planar stream and
// re-broadcasts the mean IMAGE_SIZE times; first beat one cycle after the plane's last pixel, no backpressure.
module cnn_image_pool_bcast #(
  parameter int DATA_WIDTH   = 32,
  parameter int IMAGE_WIDTH  = 32,
  parameter int IMAGE_HEIGHT = 32,
  parameter int CHANNEL_NUM  = 256
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         valid_in,
  input  logic signed [DATA_WIDTH-1:0] in,
  output logic        [DATA_WIDTH-1:0] out,
  output logic                         valid_out,
  output logic        [15:0]           ch_idx,
  output logic                         frame_done,
  output logic                         overrun
);

  localparam int IMAGE_SIZE = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam int LOG2_SIZE  = $clog2(IMAGE_SIZE);
  localparam int ACC_WIDTH  = DATA_WIDTH + LOG2_SIZE;
  localparam int CNT_W      = (LOG2_SIZE > 0) ? LOG2_SIZE : 1;
  localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(IMAGE_SIZE - 1);
  localparam logic [15:0]      LAST_CH  = 16'(CHANNEL_NUM - 1);

  logic signed [ACC_WIDTH-1:0]  r_acc;
  logic        [CNT_W-1:0]      r_pix_cnt;
  logic        [CNT_W-1:0]      r_bcast_cnt;
  logic        [15:0]           r_in_ch;
  logic        [DATA_WIDTH-1:0] r_out;
  logic                         r_valid_out;
  logic        [15:0]           r_ch_idx;
  logic                         r_overrun;

  logic signed [ACC_WIDTH-1:0]  w_sum;
  logic        [DATA_WIDTH-1:0] w_mean;
  logic                         w_last;

  assign w_sum  = r_acc + ACC_WIDTH'(in);
  // Taking the top DATA_WIDTH bits is the floor-divide by IMAGE_SIZE (arithmetic shift).
  assign w_mean = w_sum[LOG2_SIZE +: DATA_WIDTH];
  assign w_last = valid_in && (r_pix_cnt == LAST_PIX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc       <= '0;
      r_pix_cnt   <= '0;
      r_in_ch     <= '0;
      r_bcast_cnt <= '0;
      r_out       <= '0;
      r_valid_out <= 1'b0;
      r_ch_idx    <= '0;
      r_overrun   <= 1'b0;
    end else begin
      if (valid_in) begin
        if (w_last) begin
          r_acc     <= '0;
          r_pix_cnt <= '0;
          r_in_ch   <= (r_in_ch == LAST_CH) ? 16'd0 : r_in_ch + 16'd1;
        end else begin
          r_acc     <= w_sum;
          r_pix_cnt <= r_pix_cnt + 1'b1;
        end
      end

      // A plane-end load always wins; landing mid-broadcast is a rate violation.
      if (w_last) begin
        r_out       <= w_mean;
        r_valid_out <= 1'b1;
        r_bcast_cnt <= LAST_PIX;
        r_ch_idx    <= r_in_ch;
        if (r_bcast_cnt != '0) r_overrun <= 1'b1;
      end else if (r_bcast_cnt != '0) begin
        r_bcast_cnt <= r_bcast_cnt - 1'b1;
      end else begin
        r_valid_out <= 1'b0;
      end
    end
  end

  assign out        = r_out;
  assign valid_out  = r_valid_out;
  assign ch_idx     = r_ch_idx;
  assign overrun    = r_overrun;
  assign frame_done = r_valid_out && (r_bcast_cnt == '0) && (r_ch_idx == LAST_CH);

endmodule

// File: tb/tb_cnn_image_pool_bcast.sv
// Bench for cnn_image_pool_bcast on a 2x2x3 geometry: per-cycle compare against a plane-level
// model that queues IMAGE_SIZE expected beats for every completed plane.
module tb_cnn_image_pool_bcast;

  localparam int DW = 32;
  localparam int IW = 2;
  localparam int IH = 2;
  localparam int CN = 3;
  localparam int SZ = IW * IH;

  logic          clk = 1'b0;
  logic          reset;
  logic          valid_in;
  logic [DW-1:0] din;
  logic [DW-1:0] out;
  logic          valid_out;
  logic [15:0]   ch_idx;
  logic          frame_done;
  logic          overrun;

  always #5 clk = ~clk;

  cnn_image_pool_bcast #(
    .DATA_WIDTH(DW), .IMAGE_WIDTH(IW), .IMAGE_HEIGHT(IH), .CHANNEL_NUM(CN)
  ) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .in(din),
    .out(out), .valid_out(valid_out), .ch_idx(ch_idx),
    .frame_done(frame_done), .overrun(overrun)
  );

  typedef struct {
    logic [DW-1:0] val;
    logic [15:0]   ch;
    logic          fd;
  } beat_t;

  beat_t  exp_q[$];
  longint m_sum;
  int     m_pix;
  int     m_ch;
  logic   m_ovr;
  int     checks = 0;
  int     failures = 0;
  int     obs_beats;
  int     fd_pos[$];
  int     s1[12] = '{4, 8, 12, 16, -1, -2, -3, -4, 0, 0, 0, 1};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // A completed plane: floor(sum/SZ), broadcast SZ times; any beats still pending are dropped.
  task automatic model_load();
    longint q;
    beat_t  b;
    q = m_sum / SZ;
    if ((m_sum % SZ) != 0 && m_sum < 0) q = q - 1;
    if (exp_q.size() != 0) m_ovr = 1'b1;
    exp_q.delete();
    for (int i = 0; i < SZ; i++) begin
      b.val = q[DW-1:0];
      b.ch  = 16'(m_ch);
      b.fd  = (i == SZ - 1) && (m_ch == CN - 1);
      exp_q.push_back(b);
    end
    m_ch  = (m_ch + 1) % CN;
    m_sum = 0;
    m_pix = 0;
  endtask

  task automatic compare_outputs();
    beat_t b;
    if (valid_out) obs_beats++;
    if (frame_done) fd_pos.push_back(obs_beats);
    if (exp_q.size() != 0) begin
      b = exp_q.pop_front();
      chk("valid_out", 32'(valid_out), 32'd1);
      chk("out", out, b.val);
      chk("ch_idx", 32'(ch_idx), 32'(b.ch));
      chk("frame_done", 32'(frame_done), 32'(b.fd));
    end else begin
      chk("valid_out_idle", 32'(valid_out), 32'd0);
      chk("frame_done_idle", 32'(frame_done), 32'd0);
    end
    chk("overrun", 32'(overrun), 32'(m_ovr));
  endtask

  // One clock: drive at negedge, check 1 time unit after the posedge. frc forces a plane end.
  task automatic cycle(input logic v, input logic [DW-1:0] d, input logic frc);
    @(negedge clk);
    valid_in = v;
    din      = d;
    if (frc) force dut.r_pix_cnt = '1;
    @(posedge clk);
    #1;
    if (frc) begin
      force dut.r_pix_cnt = '0;
      release dut.r_pix_cnt;
    end
    if (v) begin
      m_sum += longint'($signed(d));
      if (m_pix == SZ - 1 || frc) model_load();
      else m_pix++;
    end
    compare_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    #1;
    chk("rst_valid_out", 32'(valid_out), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_out", out, 32'd0);
    chk("rst_ch_idx", 32'(ch_idx), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    exp_q.delete();
    m_sum = 0;
    m_pix = 0;
    m_ch  = 0;
    m_ovr = 1'b0;
    valid_in = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    reset    = 1'b0;
    valid_in = 1'b0;
    din      = '0;
    obs_beats = 0;
    #1;
    apply_reset();

    // Directed frame: means 10, -3, 0; 12 contiguous beats, frame_done on the last.
    for (int i = 0; i < 12; i++) cycle(1'b1, 32'(s1[i]), 1'b0);
    idle(6);

    // Gappy input on channel 0.
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 32'd4, 1'b0);
      cycle(1'b0, '0, 1'b0);
    end
    idle(5);

    // Extremes on channels 1 and 2.
    for (int i = 0; i < 4; i++) cycle(1'b1, 32'h7FFF_FFFF, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b1, 32'h8000_0000, 1'b0);
    idle(6);

    // Random full frame.
    for (int i = 0; i < 12; i++) cycle(1'b1, $urandom, 1'b0);
    idle(6);

    // Rate violation: force a second load on the broadcast's 2nd beat.
    for (int i = 0; i < 4; i++) cycle(1'b1, $urandom, 1'b0);
    cycle(1'b1, 32'd20, 1'b1);
    idle(7);
    idle(1);

    // Reset on the 2nd beat of a broadcast.
    for (int i = 0; i < 4; i++) cycle(1'b1, $urandom, 1'b0);
    cycle(1'b0, '0, 1'b0);
    #2;
    apply_reset();

    // Two frames back-to-back: directed frame then random frame.
    obs_beats = 0;
    fd_pos.delete();
    for (int i = 0; i < 12; i++) cycle(1'b1, 32'(s1[i]), 1'b0);
    for (int i = 0; i < 12; i++) cycle(1'b1, $urandom, 1'b0);
    idle(6);
    chk("b2b_beats", 32'(obs_beats), 32'd24);
    chk("b2b_fd_count", 32'(fd_pos.size()), 32'd2);
    chk("b2b_fd_first", 32'((fd_pos.size() > 0) ? fd_pos[0] : -1), 32'd12);
    chk("b2b_fd_second", 32'((fd_pos.size() > 1) ? fd_pos[1] : -1), 32'd24);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
